// File: rtl/reaction_timer_if.sv
// ---------------------------------------------------------------------------
// reaction_timer_if
// Groups the user-facing signals of the reaction timer.
//   start   : single-cycle pulse that begins a trial (debounced, synchronous)
//   stop    : single-cycle pulse carrying the user response
//   led     : cue LED, high only while the timer is counting the reaction
//   react   : last reaction time in ms, held until the next result
//   valid   : one-cycle pulse whenever react is updated
//   early   : high while a false start is being reported
//   timeout : high from a timeout until the next accepted start
// master = stimulus / button side, slave = reaction_timer.
// ---------------------------------------------------------------------------
interface reaction_timer_if;
    logic        start;
    logic        stop;
    logic        led;
    logic [15:0] react;
    logic        valid;
    logic        early;
    logic        timeout;

    modport master (
        output start,
        output stop,
        input  led,
        input  react,
        input  valid,
        input  early,
        input  timeout
    );

    modport slave (
        input  start,
        input  stop,
        output led,
        output react,
        output valid,
        output early,
        output timeout
    );
endinterface

// File: rtl/reaction_timer.sv
// ---------------------------------------------------------------------------
// reaction_timer
// Measures the user's reaction time in milliseconds. A start request arms a
// pseudo-random cue delay (MIN_DELAY_MS plus DELAY_BITS low LFSR bits); when
// it expires the cue LED lights and whole milliseconds are counted until
// stop. False starts (stop before the cue) and timeouts (MAX_MS reached) are
// flagged. The last result is held on react for the display path.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : reaction_timer_if.slave (start/stop in; led/react/valid/early/
//         timeout out, all registered)
// ---------------------------------------------------------------------------
module reaction_timer #(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_BITS   = 10,
    parameter int MAX_MS       = 9999
) (
    input  logic               clk,
    input  logic               rst,
    reaction_timer_if.slave    bus
);

    localparam int              PSC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
    localparam logic [PSC_W-1:0] PSC_ZERO = PSC_W'(0);
    localparam logic [15:0]     MIN_DELAY = 16'(MIN_DELAY_MS);
    localparam logic [15:0]     MAX_COUNT = 16'(MAX_MS);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        GO    = 3'd2,
        DONE  = 3'd3,
        EARLY = 3'd4
    } state_t;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal
    // length, so a non-zero seed never reaches the all-zero lock-up state).
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    endfunction

    // Cue delay in ms drawn from the low LFSR bits.
    function automatic logic [15:0] cue_delay(input logic [15:0] value);
        return MIN_DELAY + 16'(value[DELAY_BITS-1:0]);
    endfunction

    state_t            state_r,   state_s;
    logic [15:0]       lfsr_r;
    logic [PSC_W-1:0]  psc_r,     psc_s;
    logic [15:0]       delay_r,   delay_s;
    logic [15:0]       cnt_r,     cnt_s;
    logic [15:0]       react_r,   react_s;
    logic              led_r,     led_s;
    logic              valid_r,   valid_s;
    logic              early_r,   early_s;
    logic              timeout_r, timeout_s;
    logic              tick_s;

    assign tick_s = (psc_r == PSC_LAST);

    // Next-state and next-output logic for the trial sequencer.
    always_comb begin
        state_s   = state_r;
        delay_s   = delay_r;
        cnt_s     = cnt_r;
        react_s   = react_r;
        valid_s   = 1'b0;
        timeout_s = timeout_r;
        if (tick_s) begin
            psc_s = PSC_ZERO;
        end else begin
            psc_s = psc_r + PSC_ONE;
        end

        case (state_r)
            IDLE: begin
                // start wins over a coincident stop; stop alone is ignored
                if (bus.start) begin
                    state_s   = WAIT;
                    delay_s   = cue_delay(lfsr_r);
                    psc_s     = PSC_ZERO;
                    timeout_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // stop outranks start and any tick; start is ignored here
                if (bus.stop) begin
                    state_s = EARLY;
                end else if (tick_s) begin
                    if (delay_r <= 16'd1) begin
                        state_s = GO;
                        delay_s = 16'd0;
                        cnt_s   = 16'd0;
                        psc_s   = PSC_ZERO;
                    end else begin
                        delay_s = delay_r - 16'd1;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            GO: begin
                // stop records the count before any same-cycle increment
                if (bus.stop) begin
                    state_s = DONE;
                    react_s = cnt_r;
                    valid_s = 1'b1;
                end else if (tick_s) begin
                    if (cnt_r >= (MAX_COUNT - 16'd1)) begin
                        state_s   = DONE;
                        react_s   = MAX_COUNT;
                        valid_s   = 1'b1;
                        timeout_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end else begin
                    state_s = GO;
                end
            end
            DONE, EARLY: begin
                if (bus.start) begin
                    state_s   = WAIT;
                    delay_s   = cue_delay(lfsr_r);
                    psc_s     = PSC_ZERO;
                    timeout_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // led and early follow the next state so they are registered
        // together with it.
        led_s   = (state_s == GO);
        early_s = (state_s == EARLY);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            lfsr_r    <= LFSR_SEED;
            psc_r     <= PSC_ZERO;
            delay_r   <= 16'd0;
            cnt_r     <= 16'd0;
            react_r   <= 16'd0;
            led_r     <= 1'b0;
            valid_r   <= 1'b0;
            early_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            lfsr_r    <= lfsr_next(lfsr_r);
            psc_r     <= psc_s;
            delay_r   <= delay_s;
            cnt_r     <= cnt_s;
            react_r   <= react_s;
            led_r     <= led_s;
            valid_r   <= valid_s;
            early_r   <= early_s;
            timeout_r <= timeout_s;
        end
    end

    assign bus.led     = led_r;
    assign bus.react   = react_r;
    assign bus.valid   = valid_r;
    assign bus.early   = early_r;
    assign bus.timeout = timeout_r;

endmodule
